// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared stream handshake types and statistics counter width
package stream_pkg;

  // Valid/ready pair of one stream interface
  typedef struct packed {
    logic valid;
    logic ready;
  } stream_hs_t;

  // Width of the optional write/stall statistics counters
  localparam int STATS_CW = 32;

endpackage

// File: rtl/stream_skid_buf.sv
// rtl/stream_skid_buf.sv - output register plus skid register with fully registered ready
module stream_skid_buf
  import stream_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  stream_hs_t    in_hs;
  logic          accept;
  logic          advance;
  logic          skid_valid;
  logic [DW-1:0] skid_data;
  logic          out_valid_d;
  logic          skid_valid_d;
  logic [DW-1:0] out_data_d;
  logic [DW-1:0] skid_data_d;

  assign in_hs   = '{valid: in_valid, ready: in_ready};
  assign accept  = in_hs.valid && in_hs.ready;
  // The output register may take a new word when it is empty or being drained this cycle
  assign advance = !out_valid || out_ready;

  // Next state of both registers; skid refills out before any new word, keeping order
  always_comb begin
    out_valid_d  = out_valid;
    out_data_d   = out_data;
    skid_valid_d = skid_valid;
    skid_data_d  = skid_data;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid && advance) begin
      out_valid_d  = 1'b1;
      out_data_d   = skid_data;
      skid_valid_d = 1'b0;
    end else if (accept && advance) begin
      out_valid_d  = 1'b1;
      out_data_d   = in_data;
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end else if (advance) begin
      out_valid_d  = 1'b0;
    end
  end

  // Register update; ready is a flop so the source never sees a combinational path
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      in_ready   <= 1'b0;
    end else begin
      out_valid  <= out_valid_d;
      out_data   <= out_data_d;
      skid_valid <= skid_valid_d;
      skid_data  <= skid_data_d;
      in_ready   <= !skid_valid_d;
    end
  end

endmodule

// File: rtl/stream_fifo_wr_if.sv
// rtl/stream_fifo_wr_if.sv - stream sink to FIFO write port adapter; STREAM_FIFO_WR_IF_STATS_EN adds counters
module stream_fifo_wr_if
  import stream_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DW-1:0]       stream_s_data_i,
  input  logic                stream_s_valid_i,
  output logic                stream_s_ready_o,
  output logic [DW-1:0]       fifo_data_o,
  output logic                fifo_wr_en_o,
  input  logic                fifo_full_i,
  input  logic                flush_i
`ifdef STREAM_FIFO_WR_IF_STATS_EN
  ,
  output logic [STATS_CW-1:0] wr_count_o,
  output logic [STATS_CW-1:0] stall_count_o
`endif
);

  logic out_valid;

  stream_skid_buf #(
    .DW(DW)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush_i),
    .in_data  (stream_s_data_i),
    .in_valid (stream_s_valid_i),
    .in_ready (stream_s_ready_o),
    .out_data (fifo_data_o),
    .out_valid(out_valid),
    .out_ready(!fifo_full_i)
  );

  // Write strobe is combinational so a held word lands the same cycle full drops; never during reset
  assign fifo_wr_en_o = out_valid && !fifo_full_i && !rst;

`ifdef STREAM_FIFO_WR_IF_STATS_EN
  // Free-running write and stall counters; only reset clears them, flush does not
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count_o    <= '0;
      stall_count_o <= '0;
    end else begin
      if (fifo_wr_en_o) wr_count_o <= wr_count_o + 1'b1;
      if (out_valid && fifo_full_i) stall_count_o <= stall_count_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_fifo_wr_if.sv
// tb/tb_stream_fifo_wr_if.sv - randomized self-checking bench for stream_fifo_wr_if
module tb_stream_fifo_wr_if;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] stream_s_data_i;
  logic          stream_s_valid_i;
  logic          stream_s_ready_o;
  logic [DW-1:0] fifo_data_o;
  logic          fifo_wr_en_o;
  logic          fifo_full_i;
  logic          flush_i;
`ifdef STREAM_FIFO_WR_IF_STATS_EN
  logic [31:0]   wr_count_o;
  logic [31:0]   stall_count_o;
`endif

  stream_fifo_wr_if #(
    .DW(DW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stream_s_data_i (stream_s_data_i),
    .stream_s_valid_i(stream_s_valid_i),
    .stream_s_ready_o(stream_s_ready_o),
    .fifo_data_o     (fifo_data_o),
    .fifo_wr_en_o    (fifo_wr_en_o),
    .fifo_full_i     (fifo_full_i),
    .flush_i         (flush_i)
`ifdef STREAM_FIFO_WR_IF_STATS_EN
    ,
    .wr_count_o      (wr_count_o),
    .stall_count_o   (stall_count_o)
`endif
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;

  // Reference model: words currently held by the block, oldest first
  logic [DW-1:0] held[$];
  logic          ready_exp = 1'b0;
  logic [31:0]   wr_cnt_exp = '0;
  logic [31:0]   stall_cnt_exp = '0;
  logic [DW-1:0] next_word = '0;
  int            words_written = 0;
  int            words_accepted = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs against the model, advance the model
  task automatic step(input logic v, input logic f, input logic fl, input logic r);
    logic exp_wr;
    logic stall;
    logic acc;
    @(negedge clk);
    rst              = r;
    stream_s_valid_i = v;
    stream_s_data_i  = next_word;
    fifo_full_i      = f;
    flush_i          = fl;
    #1;
    exp_wr = (held.size() > 0) && !f && !r;
    stall  = (held.size() > 0) && f && !r;
    check_eq("ready", {63'd0, stream_s_ready_o}, {63'd0, ready_exp});
    check_eq("wr_en", {63'd0, fifo_wr_en_o}, {63'd0, exp_wr});
    if (exp_wr && fifo_wr_en_o) check_eq("wr_data", {32'd0, fifo_data_o}, {32'd0, held[0]});
`ifdef STREAM_FIFO_WR_IF_STATS_EN
    check_eq("wr_count", {32'd0, wr_count_o}, {32'd0, wr_cnt_exp});
    check_eq("stall_count", {32'd0, stall_count_o}, {32'd0, stall_cnt_exp});
`endif
    acc = v && stream_s_ready_o && !r;
    if (r) begin
      held.delete();
      ready_exp     = 1'b0;
      wr_cnt_exp    = '0;
      stall_cnt_exp = '0;
    end else begin
      if (exp_wr) begin
        void'(held.pop_front());
        wr_cnt_exp = wr_cnt_exp + 1;
        words_written++;
      end
      if (stall) stall_cnt_exp = stall_cnt_exp + 1;
      if (fl) held.delete();
      else if (acc) held.push_back(stream_s_data_i);
      ready_exp = (held.size() < 2);
    end
    if (acc) begin
      next_word = next_word + 1;
      words_accepted++;
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    words_written  = 0;
    words_accepted = 0;
  endtask

  initial begin
    int          guard;
    logic [31:0] stall_start;

    rst              = 1'b1;
    stream_s_valid_i = 1'b0;
    stream_s_data_i  = '0;
    fifo_full_i      = 1'b0;
    flush_i          = 1'b0;

    // Reset, then a 10-word burst 0x0..0x9 with full never asserted
    do_reset(3);
    check_eq("rst_data", {32'd0, fifo_data_o}, 64'd0);
    next_word = '0;
    guard = 0;
    while (words_accepted < 10 && guard < 50) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("burst_written", words_written, 10);

    // Backpressure: full held for 5 cycles in the middle of a continuous burst
    do_reset(2);
    stall_start = stall_cnt_exp;
    for (int i = 0; i < 30; i++) step(1'b1, (i >= 8 && i < 13), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("bp_no_loss", words_written, words_accepted);
`ifdef STREAM_FIFO_WR_IF_STATS_EN
    check_eq("bp_stall5", {32'd0, stall_count_o}, {32'd0, stall_start + 32'd5});
`endif

    // Random valid (50%) and full (30%) until 10000 words are accepted
    do_reset(2);
    guard = 0;
    while (words_accepted < 10000 && guard < 60000) begin
      step(($urandom % 2) == 1, ($urandom % 10) < 3, 1'b0, 1'b0);
      guard++;
    end
    check_eq("rand_done", words_accepted, 10000);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("rand_written", words_written, 10000);
`ifdef STREAM_FIFO_WR_IF_STATS_EN
    check_eq("rand_wr_count", {32'd0, wr_count_o}, 64'd10000);
`endif

    // Flush with both registers occupied
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("flush_ready", {63'd0, stream_s_ready_o}, 64'd1);
    check_eq("flush_empty", {63'd0, fifo_wr_en_o}, 64'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    // Flush dropping a word accepted in the same cycle
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-burst with the skid register occupied and full released during reset
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("rst_mid_data", {32'd0, fifo_data_o}, 64'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

`ifdef STREAM_FIFO_WR_IF_STATS_EN
    // Write counter wrap from all-ones
    step(1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    force dut.wr_count_o = 32'hFFFF_FFFF;
    #1;
    release dut.wr_count_o;
    wr_cnt_exp = 32'hFFFF_FFFF;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("wr_wrap", {32'd0, wr_count_o}, 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_fifo_wr_if.md
# stream_fifo_wr_if

Stream-sink to FIFO-write adapter: accepts a valid/ready stream (slave side) and pushes each accepted word into a standard synchronous FIFO write port (data, write enable, full flag). It is the write-side counterpart of the FIFO-to-stream read adapter: streaming producers such as the video capture path feed a FIFO through this block, and the read adapter drains it on the far side. A two-entry register pipeline (output register plus skid register) keeps `stream_s_ready_o` fully registered and sustains one word per clock while the FIFO is not full.

## Interface
- `DW`, default 32: data width in bits, ≥ 1.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stream_s_data_i`  in  DW  stream data.
- `stream_s_valid_i`  in  1  stream word valid.
- `stream_s_ready_o`  out  1  block can accept; driven directly from a flop.
- `fifo_data_o`  out  DW  FIFO write data; driven directly from a flop.
- `fifo_wr_en_o`  out  1  FIFO write strobe, combinational: `out_valid && !fifo_full_i`.
- `fifo_full_i`  in  1  FIFO full; a write while full is never issued.
- `flush_i`  in  1  synchronous discard of all buffered words.
- `wr_count_o`  out  32  words written to FIFO (only with `STREAM_FIFO_WR_IF_STATS_EN`).
- `stall_count_o`  out  32  cycles with `out_valid && fifo_full_i` (only with `STREAM_FIFO_WR_IF_STATS_EN`).

## Operation
- Internal state: output register (`out_valid`, `out_data` = `fifo_data_o`) and skid register (`skid_valid`, `skid_data`).
- Accept = `stream_s_valid_i && stream_s_ready_o`. Advance = `!out_valid || fifo_wr_en_o`.
- Per cycle, priority order:
  1. `flush_i`: `out_valid` ← 0, `skid_valid` ← 0, and any word presented in this cycle is dropped even if accepted. The current-cycle `fifo_wr_en_o` still commits, because the strobe is combinational.
  2. `skid_valid && advance`: `out` ← skid and `skid_valid` ← 0. No accept is possible in this case because ready is low.
  3. `accept && advance`: `out` ← input.
  4. `accept && !advance`: skid ← input.
  5. `advance` with nothing new: `out_valid` ← 0.
- `stream_s_ready_o` next = `!skid_valid_next`. After flush it is 1.
- Data is never reordered, duplicated or dropped, except by flush.
- Reset values: `stream_s_ready_o` 0, `fifo_data_o` 0, `out_valid` 0, `skid_valid` 0, counters 0. Consequently `fifo_wr_en_o` is 0 during and after reset.
- Reset mid-transfer discards both registers. No FIFO write occurs in a cycle where `rst` is high.

## Timing
- Latency: a word accepted in cycle N is presented with `fifo_wr_en_o` = 1 in cycle N+1 if `fifo_full_i` = 0.
- Throughput: 1 word/clk with full never asserted.
- `stream_s_ready_o` first rises in the cycle after `rst` deasserts.
- Full asserted with `out_valid`: the next accepted word goes to skid and ready drops the following cycle. At most 2 words are held.
- Full deasserts: out writes that cycle, skid moves to out at the edge, and ready rises one cycle later. Restart bubble ≤ 1 cycle on input.
- `stream_s_valid_i` may toggle freely; the source must hold data and valid only while ready is low.

## Configuration
- `STREAM_FIFO_WR_IF_STATS_EN` defined: `wr_count_o` increments on each `fifo_wr_en_o`, and `stall_count_o` increments each cycle where `out_valid && fifo_full_i`. Both are 32-bit, wrap modulo 2^32, reset to 0 and are not cleared by flush.
- Not defined: neither port exists and no counter logic is built. Datapath behaviour is identical.

## Structure
- Shared package `stream_pkg`: stream handshake typedef, `STATS_CW` = 32 counter width constant.
- One natural sub-module: `stream_skid_buf`, holding the skid and output registers plus ready generation and parameterised on `DW`. The top level adds the FIFO strobe and the optional counters.

## Test plan
- Reset then streaming, DW = 32: valid held high with data 0x0..0x9, full = 0 → ready rises 1 cycle after reset; `fifo_wr_en_o` high for 10 consecutive cycles beginning 1 cycle after first accept; data 0x0..0x9 in order.
- Backpressure: full asserted for 5 cycles mid-burst → ready low after ≤ 2 held words; no `fifo_wr_en_o` while full; the sequence resumes without loss or duplication; `stall_count_o` = 5.
- Random valid (50%) and random full (30%) over 10 000 words → scoreboard matches exactly; `wr_count_o` = 10 000; a write never coincides with full.
- Flush with both registers occupied (full = 1) → next cycle `out_valid` = 0, ready = 1, and the next written word is the first one accepted after the flush.
- Reset asserted mid-burst with skid occupied → outputs return to reset values next cycle and no `fifo_wr_en_o` occurs until a new accept.
- Counter wrap with stats enabled: preload via force to 0xFFFF_FFFF, then one write → `wr_count_o` = 0.
